// File: rtl/cbus_rr_arbiter_pkg.sv
// Shared cache-bus package: request/response structs used on both sides of the
// arbiter, the arbiter state encoding and a small index helper.
package cbus_rr_arbiter_pkg;

    localparam int CBUS_AW = 32;
    localparam int CBUS_DW = 32;
    localparam int CBUS_LW = 4;    // burst length field, beats = len + 1

    typedef struct packed {
        logic               valid;
        logic               write;
        logic [CBUS_AW-1:0] addr;
        logic [CBUS_DW-1:0] wdata;
        logic [CBUS_LW-1:0] len;
    } cbus_req_t;

    typedef struct packed {
        logic               ready;
        logic               last;
        logic [CBUS_DW-1:0] rdata;
    } cbus_resp_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Next index with wrap from n-1 back to 0.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cbus_rr_arbiter_pick.sv
// cbus_rr_pick: combinational rotate-priority encoder.
// Scans the valid vector starting at rr_ptr, wrapping past the top index, and
// returns the first set position.
//   valid  : per-requester valid bits
//   rr_ptr : index with highest priority this round (must be < NUM_INPUTS)
//   any    : at least one valid bit set
//   winner : selected index ('0 when any is low)
module cbus_rr_pick #(
    parameter int NUM_INPUTS = 4,
    parameter int IDX_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic [NUM_INPUTS-1:0] valid,
    input  logic [IDX_W-1:0]      rr_ptr,
    output logic                  any,
    output logic [IDX_W-1:0]      winner
);

    int idx;

    // Walk from the farthest offset down to offset 0 so the closest valid
    // position to rr_ptr is the last one written and therefore wins.
    always_comb begin
        any    = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
            if (valid[idx]) begin
                any    = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// cbus_rr_arbiter: shares one cache-bus master port between NUM_INPUTS
// requesters. One grant per transaction, held for the whole burst and released
// on the beat carrying oresp.ready && oresp.last. A release always costs one
// IDLE cycle before the next grant.
//
// Build option: define CBUS_ARB_RR_EN for round-robin selection starting at
// rr_ptr; otherwise fixed priority, lowest valid index wins and rr_ptr stays 0.
//
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   ireqs      : requester requests, index 0 in the LSBs
//   iresps     : per-requester responses, only the grantee sees oresp
//   oreq       : request to memory side (pass-through of grantee while busy)
//   oresp      : response from memory side
//   busy       : grant held
//   grant      : current or most recent grantee
module cbus_rr_arbiter
    import cbus_rr_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int IDX_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  cbus_req_t  [NUM_INPUTS-1:0]  ireqs,
    output cbus_resp_t [NUM_INPUTS-1:0]  iresps,
    output cbus_req_t                    oreq,
    input  cbus_resp_t                   oresp,
    output logic                         busy,
    output logic [IDX_W-1:0]             grant
);

    arb_state_t            state;
    logic [IDX_W-1:0]      rr_ptr;
    logic [NUM_INPUTS-1:0] req_valid;
    logic                  any;
    logic [IDX_W-1:0]      winner;

    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) req_valid[i] = ireqs[i].valid;
    end

    cbus_rr_pick #(
        .NUM_INPUTS (NUM_INPUTS),
        .IDX_W      (IDX_W)
    ) u_pick (
        .valid  (req_valid),
        .rr_ptr (rr_ptr),
        .any    (any),
        .winner (winner)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ARB_IDLE;
            busy   <= 1'b0;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (any) begin
                        grant <= winner;
                        busy  <= 1'b1;
                        state <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    // Grantee dropping valid mid-burst does not release;
                    // only the memory side's last beat does.
                    if (oresp.ready && oresp.last) begin
                        busy  <= 1'b0;
                        state <= ARB_IDLE;
`ifdef CBUS_ARB_RR_EN
                        rr_ptr <= IDX_W'(wrap_inc(int'(grant), NUM_INPUTS));
`else
                        rr_ptr <= '0;
`endif
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    // Pass-through is combinational on the registered state, so an async reset
    // zeroes the outputs in the same cycle it is asserted.
    always_comb begin
        oreq   = '0;
        iresps = '0;
        if (state == ARB_BUSY) begin
            oreq          = ireqs[grant];
            iresps[grant] = oresp;
        end
    end

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
module tb_cbus_rr_arbiter;
    import cbus_rr_arbiter_pkg::*;

    logic                 clk;
    logic                 reset;
    cbus_req_t  [3:0]     ireqs;
    cbus_resp_t [3:0]     iresps;
    cbus_req_t            oreq;
    cbus_resp_t           oresp;
    logic                 busy;
    logic [1:0]           grant;

    cbus_rr_arbiter #(.NUM_INPUTS(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .ireqs  (ireqs),
        .iresps (iresps),
        .oreq   (oreq),
        .oresp  (oresp),
        .busy   (busy),
        .grant  (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [3:0] vm;    // valid mask driven this cycle
        logic       eb;    // expected busy
        logic [1:0] eg;    // expected grant
        logic [3:0] erm;   // expected iresps[*].ready mask
        logic       el;    // expected last on the grantee response
    } vec_t;

    int         n_cmp;
    int         n_fail;
    int         beat;
    int         quota[4];
    logic       exp_busy;
    logic [1:0] exp_g;
    int         expq[$];
    vec_t       tbl[7];

    task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk(input logic eb, input logic [1:0] eg);
        cmp("busy", 128'(busy), 128'(eb));
        cmp("grant", 128'(grant), 128'(eg));
        cmp("oreq", 128'(oreq), eb ? 128'(ireqs[eg]) : 128'd0);
        for (int k = 0; k < 4; k++)
            cmp($sformatf("iresp%0d", k), 128'(iresps[k]),
                (eb && k == int'(eg)) ? 128'(oresp) : 128'd0);
    endtask

    // Memory-side responder: ready every cycle, last on beat == len.
    task automatic drive_resp();
        if (oreq.valid) begin
            oresp.ready = 1'b1;
            oresp.last  = (beat == int'(oreq.len));
            oresp.rdata = {8'hA5, 8'(beat), oreq.addr[15:0]};
        end else begin
            oresp = '0;
        end
    endtask

    task automatic set_valid(input logic [3:0] m);
        for (int k = 0; k < 4; k++) ireqs[k].valid = m[k];
    endtask

    task automatic set_len(input int l);
        for (int k = 0; k < 4; k++) ireqs[k].len = 4'(l);
    endtask

    function automatic logic any_valid();
        logic a;
        a = 1'b0;
        for (int k = 0; k < 4; k++) a = a | ireqs[k].valid;
        return a;
    endfunction

    // One clock: respond and check at negedge, advance the expectation model
    // after posedge. tbl=1 uses the supplied expectations instead of the model.
    task automatic tick(input bit tb_mode, input logic eb, input logic [1:0] eg,
                        input logic [3:0] erm, input logic el);
        logic fin;
        logic anyv;
        logic [3:0] rm;
        @(negedge clk);
        drive_resp();
        #1;
        if (tb_mode) begin
            chk(eb, eg);
            for (int k = 0; k < 4; k++) rm[k] = iresps[k].ready;
            cmp("ready_mask", 128'(rm), 128'(erm));
            cmp("last", 128'(iresps[eg].last), 128'(el));
        end else begin
            chk(exp_busy, exp_g);
        end
        @(posedge clk);
        fin  = oresp.ready && oresp.last;
        anyv = any_valid();
        if (oresp.ready) beat = fin ? 0 : beat + 1;
        #1;
        if (!tb_mode) begin
            if (exp_busy) begin
                if (fin) begin
                    exp_busy = 1'b0;
                    quota[exp_g]--;
                    if (quota[exp_g] <= 0) ireqs[exp_g].valid = 1'b0;
                end
            end else if (anyv) begin
                exp_busy = 1'b1;
                if (expq.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL sb_underflow: got grant without expected entry, expected none");
                    exp_g = 2'd0;
                end else begin
                    exp_g = 2'(expq.pop_front());
                end
            end
        end
    endtask

    task automatic run_sb(input int max_cycles);
        for (int c = 0; c < max_cycles; c++) begin
            if (expq.size() == 0 && !exp_busy && !any_valid()) break;
            tick(1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
        end
        cmp("sb_drain", 128'(expq.size()), 128'd0);
        cmp("sb_idle", 128'(exp_busy), 128'd0);
        set_valid(4'b0000);
        expq.delete();
    endtask

    task automatic do_reset();
        set_valid(4'b0000);
        reset    = 1'b1;
        exp_busy = 1'b0;
        exp_g    = 2'd0;
        beat     = 0;
        oresp    = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic set_quota(input int q0, input int q1, input int q2, input int q3);
        quota[0] = q0; quota[1] = q1; quota[2] = q2; quota[3] = q3;
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; beat = 0;
        exp_busy = 1'b0; exp_g = 2'd0;
        set_quota(0, 0, 0, 0);
        oresp = '0;
        for (int k = 0; k < 4; k++) begin
            ireqs[k].valid = 1'b0;
            ireqs[k].write = k[0];
            ireqs[k].addr  = 32'h1000_0000 + 32'(k * 256);
            ireqs[k].wdata = 32'hCAFE_0000 | 32'(k);
            ireqs[k].len   = 4'd3;
        end

        // Single request on input 2, len=3: one-cycle grant latency, 4 beats.
        tbl[0] = '{vm: 4'b0100, eb: 1'b0, eg: 2'd0, erm: 4'b0000, el: 1'b0};
        tbl[1] = '{vm: 4'b0100, eb: 1'b1, eg: 2'd2, erm: 4'b0100, el: 1'b0};
        tbl[2] = '{vm: 4'b0100, eb: 1'b1, eg: 2'd2, erm: 4'b0100, el: 1'b0};
        tbl[3] = '{vm: 4'b0100, eb: 1'b1, eg: 2'd2, erm: 4'b0100, el: 1'b0};
        tbl[4] = '{vm: 4'b0100, eb: 1'b1, eg: 2'd2, erm: 4'b0100, el: 1'b1};
        tbl[5] = '{vm: 4'b0000, eb: 1'b0, eg: 2'd2, erm: 4'b0000, el: 1'b0};
        tbl[6] = '{vm: 4'b0000, eb: 1'b0, eg: 2'd2, erm: 4'b0000, el: 1'b0};

        // Reset holds everything at zero even with a valid request present.
        reset = 1'b1;
        ireqs[2].valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk(1'b0, 2'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            set_valid(tbl[i].vm);
            tick(1'b1, tbl[i].eb, tbl[i].eg, tbl[i].erm, tbl[i].el);
        end

        // Contention: all inputs valid, input 0 wants two bursts.
        do_reset();
        set_len(1);
        set_quota(2, 1, 1, 1);
`ifdef CBUS_ARB_RR_EN
        expq = '{0, 1, 2, 3, 0};
`else
        expq = '{0, 0, 1, 2, 3};
`endif
        set_valid(4'b1111);
        run_sb(60);

        // Inputs 1 and 3: input 1 wants two bursts.
        do_reset();
        set_len(2);
        set_quota(0, 2, 0, 1);
`ifdef CBUS_ARB_RR_EN
        expq = '{1, 3, 1};
`else
        expq = '{1, 1, 3};
`endif
        set_valid(4'b1010);
        run_sb(60);

        // Back-to-back: input 1 still valid at its last beat.
        do_reset();
        set_len(0);
        set_quota(1, 2, 1, 0);
`ifdef CBUS_ARB_RR_EN
        expq = '{0, 1, 2, 1};
`else
        expq = '{0, 1, 1, 2};
`endif
        set_valid(4'b0111);
        run_sb(60);

        // Reset on beat 2 of a len=7 burst, then re-arbitrate from rr_ptr=0.
        set_len(7);
        set_quota(1, 0, 0, 0);
        expq = '{0};
        set_valid(4'b0001);
        repeat (3) tick(1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
        @(negedge clk);
        drive_resp();
        #1;
        chk(exp_busy, exp_g);
        cmp("beat_before_reset", 128'(beat), 128'd2);
        reset = 1'b1;
        #1;
        chk(1'b0, 2'd0);
        set_valid(4'b0000);
        exp_busy = 1'b0;
        exp_g    = 2'd0;
        beat     = 0;
        oresp    = '0;
        expq.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_len(1);
        set_quota(0, 1, 0, 1);
        expq = '{1, 3};
        set_valid(4'b1010);
        run_sb(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
